// File: rtl/maq_h_if.sv
// Hours-stage bus: minutes carry, tick qualifier and adjust controls in,
// BCD hour, AM/PM flag and day-rollover pulse out.
//   slave  : the hours stage (maq_h)
//   master : whatever drives it (minutes stage / panel / testbench)
interface maq_h_if;
  logic       maqh_enable;
  logic       maqh_incremento;
  logic       maqh_ajuste;
  logic       maqh_botao;
  logic [3:0] maqh_lsd;
  logic [1:0] maqh_msd;
  logic       maqh_pm;
  logic       maqh_incrementadia;

  modport slave (
    input  maqh_enable, maqh_incremento, maqh_ajuste, maqh_botao,
    output maqh_lsd, maqh_msd, maqh_pm, maqh_incrementadia
  );
  modport master (
    output maqh_enable, maqh_incremento, maqh_ajuste, maqh_botao,
    input  maqh_lsd, maqh_msd, maqh_pm, maqh_incrementadia
  );
endinterface

// File: rtl/maq_h.sv
// maq_h - hours stage of the digital clock.
// Rising-edge detects the minutes carry level and advances a BCD hour
// (00..23, or 12,01..11 with AM/PM). A manual adjust path steps the hour
// on button edges. A one-cycle day pulse is emitted on carry-path rollover.
// Ports:
//   maqh_clock : system clock (rising edge)
//   maqh_reset : async active-low reset
//   bus        : maq_h_if.slave (enable, incremento, ajuste, botao in;
//                lsd, msd, pm, incrementadia out)
module maq_h #(
  parameter bit MODO_24H = 1'b1
) (
  input  logic     maqh_clock,
  input  logic     maqh_reset,
  maq_h_if.slave   bus
);

  logic       r_carry_prev, r_botao_prev, r_pending, r_pm, r_dia;
  logic [3:0] r_lsd;
  logic [1:0] r_msd;

  logic       w_edge_c, w_edge_b, w_pend_eff;
  logic [3:0] w_nlsd;
  logic [1:0] w_nmsd;
  logic       w_npm, w_roll;

  assign w_edge_c   = bus.maqh_incremento & ~r_carry_prev;
  assign w_edge_b   = bus.maqh_botao & ~r_botao_prev;
  assign w_pend_eff = r_pending | w_edge_c;

  // Next hour value; w_roll marks the step that ends the day.
  always_comb begin
    w_nlsd = r_lsd + 4'd1;
    w_nmsd = r_msd;
    w_npm  = r_pm;
    w_roll = 1'b0;
    if (MODO_24H) begin
      if (r_msd == 2'd2 && r_lsd == 4'd3) begin
        w_nlsd = 4'd0;
        w_nmsd = 2'd0;
        w_roll = 1'b1;
      end else if (r_lsd == 4'd9) begin
        w_nlsd = 4'd0;
        w_nmsd = r_msd + 2'd1;
      end
    end else begin
      if (r_msd == 2'd1 && r_lsd == 4'd2) begin
        w_nlsd = 4'd1;
        w_nmsd = 2'd0;
      end else if (r_msd == 2'd0 && r_lsd == 4'd9) begin
        w_nlsd = 4'd0;
        w_nmsd = 2'd1;
      end else if (r_msd == 2'd1 && r_lsd == 4'd1) begin
        // 11 -> 12 flips AM/PM; PM->AM is the day boundary
        w_nlsd = 4'd2;
        w_npm  = ~r_pm;
        w_roll = r_pm;
      end
    end
  end

  always_ff @(posedge maqh_clock or negedge maqh_reset) begin
    if (!maqh_reset) begin
      // Prev regs at 1 so a level already high at release is not an edge
      r_carry_prev <= 1'b1;
      r_botao_prev <= 1'b1;
      r_pending    <= 1'b0;
      r_dia        <= 1'b0;
      r_pm         <= 1'b0;
      r_lsd        <= MODO_24H ? 4'd0 : 4'd2;
      r_msd        <= MODO_24H ? 2'd0 : 2'd1;
    end else begin
      r_carry_prev <= bus.maqh_incremento;
      r_botao_prev <= bus.maqh_botao;
      r_dia        <= 1'b0;
      if (bus.maqh_ajuste) begin
        r_pending <= 1'b0;
        if (w_edge_b) begin
          r_lsd <= w_nlsd;
          r_msd <= w_nmsd;
          r_pm  <= w_npm;
        end
      end else if (w_pend_eff) begin
        if (bus.maqh_enable) begin
          r_lsd     <= w_nlsd;
          r_msd     <= w_nmsd;
          r_pm      <= w_npm;
          r_dia     <= w_roll;
          r_pending <= 1'b0;
        end else begin
          // Saturating: further edges while waiting are lost
          r_pending <= 1'b1;
        end
      end
    end
  end

  assign bus.maqh_lsd           = r_lsd;
  assign bus.maqh_msd           = r_msd;
  assign bus.maqh_pm            = MODO_24H ? 1'b0 : r_pm;
  assign bus.maqh_incrementadia = r_dia;

endmodule

// File: doc/maq_h.md
Name: maq_h

Overview:
Hours stage of the digital clock, directly downstream of the minutes stage. It consumes the minutes-to-hours carry level, rising-edge detects it and advances a BCD hour count (24 h or 12 h with AM/PM). It also provides a manual hour-adjust path and emits a one-cycle day-rollover pulse for a future date stage.

Parameters:
MODO_24H, 1, 1 = count 00..23; 0 = count 12,01..11 with AM/PM flag

Ports:
maqh_clock  input  1  system clock, all state on rising edge
maqh_reset  input  1  asynchronous, active-low reset
maqh_enable  input  1  count-tick qualifier shared with minutes stage
maqh_incremento  input  1  carry level from minutes stage; high for a full minute period after 59->00 wrap
maqh_ajuste  input  1  manual adjust mode; carry path suspended while high
maqh_botao  input  1  debounced, synchronous adjust button; one hour per rising edge while maqh_ajuste=1
maqh_lsd  output  4  hour units, BCD 0..9
maqh_msd  output  2  hour tens, BCD 0..2
maqh_pm  output  1  PM flag (12 h mode); constant 0 when MODO_24H=1
maqh_incrementadia  output  1  one-cycle pulse on day rollover (carry path only)

Behaviour:
- Reset (async, maqh_reset=0): 24 h -> msd=0, lsd=0 (00); 12 h -> msd=1, lsd=2, pm=0 (12 AM). incrementadia=0, pending=0, carry_prev=1, botao_prev=1. Prev regs reset to 1 so a level already high at reset release is not counted.
- Edge detect: carry_prev <= maqh_incremento and botao_prev <= maqh_botao on every clock, independent of enable/ajuste. edge_c = incremento & ~carry_prev; edge_b = botao & ~botao_prev.
- Carry path (ajuste=0): pend_eff = pending | edge_c. If pend_eff & enable: step hour at this clock edge, pending <= 0. If pend_eff & ~enable: pending <= 1 (held until next enable cycle). Second edge while pending is already set is absorbed; pending saturates at 1 and that step is lost.
- Latency: with enable=1, outputs show the new hour at the first clock edge that samples incremento=1 after a 0. No extra pipeline stage.
- Adjust path (ajuste=1): carry edges ignored; pending forced to 0. Each edge_b steps the hour at that clock edge, regardless of enable. Adjust steps never assert incrementadia.
- Leaving adjust: carry_prev has tracked incremento throughout, so a level already high on exit does not step.
- Step sequence 24 h: lsd+1; lsd 9->0 with msd+1; msd=2,lsd=3 -> 00.
- Step sequence 12 h: 12->01; 09->10; 10->11; 11->12 with pm toggled. Values 00 and 13..23 are never produced.
- Day rollover: incrementadia=1 for exactly one clock after a carry-path step 23->00 (24 h) or 11 PM->12 AM (12 h, pm 1->0). Otherwise 0.
- Outputs are all registered. msd/lsd never hold an illegal BCD value.
- Reset mid-operation clears pending and any incrementadia pulse immediately (asynchronous).

Test Plan:
- Reset with incremento=1 held, then release, enable=1 for 10 cycles -> hour stays 00, no step.
- 24 h: 23 carry pulses (0->1->0, enable=1) -> 23 (msd=2, lsd=3). 24th pulse -> 00, incrementadia high for exactly 1 cycle.
- Carry edge with enable=0 for 5 cycles, then enable=1 -> single step on the first enable cycle. Two edges before enable -> still only one step.
- ajuste=1 with 3 botao edges from 22 -> 22, 23, 00, 01. incrementadia stays 0. Carry edge during adjust -> no step.
- MODO_24H=0: from reset, 11 pulses -> 11 AM. 12th -> 12 PM (pm=1). Further 12 pulses -> 12 AM with incrementadia pulse.
- Assert reset while pending=1 and incrementadia=1 -> outputs 00/12 AM immediately. After release no deferred step occurs.
